// File: rtl/hazard_ctrl_unit_if.sv
// Hazard unit bus: pipeline-side instruction/status signals and the
// hazard unit's forward/stall/flush responses.
interface hazard_ctrl_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] instr_de;
    logic [XLEN-1:0] instr_mw;
    logic            reg_write_mw;
    logic            br_taken;
    logic            is_mret_mw;
    logic [1:0]      interrupt;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            stall_if;
    logic            stall_de;
    logic            bubble_mw;
    logic            flush_de;
    logic            flush_mw;
    logic            busy;

    // Pipeline side: drives stage contents, consumes hazard decisions.
    modport master (
        output instr_de, instr_mw, reg_write_mw, br_taken, is_mret_mw, interrupt,
        input  fwd_a, fwd_b, stall_if, stall_de, bubble_mw, flush_de, flush_mw, busy
    );

    // Hazard unit side.
    modport slave (
        input  instr_de, instr_mw, reg_write_mw, br_taken, is_mret_mw, interrupt,
        output fwd_a, fwd_b, stall_if, stall_de, bubble_mw, flush_de, flush_mw, busy
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller between DE and MW stages: per-operand
// forwarding (MW result or writeback-hold register), multi-cycle load-use
// stalls and multi-cycle interrupt/mret flush sequencing.
module hazard_ctrl_unit #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    hazard_ctrl_unit_if.slave hz
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [2:0]        cnt;
    logic [2:0]        cnt_n;

    logic [REG_AW-1:0] hold_rd;
    logic              hold_we;

    logic [6:0]        op_de;
    logic [6:0]        op_mw;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd_mw;
    logic              rs1_used;
    logic              rs2_used;
    logic              mw_wr;
    logic              mw_load;
    logic              load_use;
    logic              evt;
    logic [1:0]        fwd_a_c;
    logic [1:0]        fwd_b_c;

    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              stall_o;
    logic              flush_de_o;
    logic              flush_mw_o;

    logic              unused_bits;
    assign unused_bits = ^{hz.instr_de, hz.instr_mw};

    // Field extraction and register-usage decode for both stages.
    always_comb begin
        op_de    = hz.instr_de[6:0];
        op_mw    = hz.instr_mw[6:0];
        rs1      = hz.instr_de[15 +: REG_AW];
        rs2      = hz.instr_de[20 +: REG_AW];
        rd_mw    = hz.instr_mw[7 +: REG_AW];
        rs1_used = !((op_de == OP_LUI) || (op_de == OP_AUIPC) || (op_de == OP_JAL));
        rs2_used = (op_de == OP_REG) || (op_de == OP_STORE) || (op_de == OP_BRANCH);
        mw_wr    = hz.reg_write_mw && (rd_mw != '0) &&
                   (op_mw != OP_STORE) && (op_mw != OP_BRANCH);
        mw_load  = (op_mw == OP_LOAD);
        load_use = mw_load && mw_wr &&
                   ((rs1_used && (rd_mw == rs1)) || (rs2_used && (rd_mw == rs2)));
        evt      = (hz.interrupt == 2'b01) || hz.is_mret_mw;
    end

    // Forward selects per operand; the MW result outranks the hold register.
    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (rs1_used && mw_wr && !mw_load && (rd_mw == rs1))
            fwd_a_c = 2'b01;
        else if (rs1_used && hold_we && (hold_rd == rs1) && (rs1 != '0))
            fwd_a_c = 2'b10;
        if (rs2_used && mw_wr && !mw_load && (rd_mw == rs2))
            fwd_b_c = 2'b01;
        else if (rs2_used && hold_we && (hold_rd == rs2) && (rs2 != '0))
            fwd_b_c = 2'b10;
    end

    // Next-state and output decode; the counter holds cycles remaining after
    // the current one, so a state is left on the edge where it would reach 0.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        fwd_a_o    = 2'b00;
        fwd_b_o    = 2'b00;
        stall_o    = 1'b0;
        flush_de_o = 1'b0;
        flush_mw_o = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (evt) begin
                        flush_de_o = 1'b1;
                        flush_mw_o = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = FLUSH;
                            cnt_n   = FL_RELOAD;
                        end
                    end else if (hz.br_taken) begin
                        flush_de_o = 1'b1;
                        fwd_a_o    = fwd_a_c;
                        fwd_b_o    = fwd_b_c;
                    end else if (load_use) begin
                        stall_o = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_n = LD_STALL;
                            cnt_n   = LS_RELOAD;
                        end
                    end else begin
                        fwd_a_o = fwd_a_c;
                        fwd_b_o = fwd_b_c;
                    end
                end
                LD_STALL: begin
                    if (evt) begin
                        flush_de_o = 1'b1;
                        flush_mw_o = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = FLUSH;
                            cnt_n   = FL_RELOAD;
                        end else begin
                            state_n = RUN;
                            cnt_n   = '0;
                        end
                    end else begin
                        stall_o = 1'b1;
                        cnt_n   = cnt - 3'd1;
                        if (cnt <= 3'd1) begin
                            state_n = RUN;
                            cnt_n   = '0;
                        end
                    end
                end
                FLUSH: begin
                    flush_de_o = 1'b1;
                    flush_mw_o = 1'b1;
                    if (evt && (FLUSH_CYCLES > 1)) begin
                        cnt_n = FL_RELOAD;
                    end else begin
                        cnt_n = cnt - 3'd1;
                        if (evt || (cnt <= 3'd1)) begin
                            state_n = RUN;
                            cnt_n   = '0;
                        end
                    end
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // FSM state and cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Writeback-hold register: tracks the last MW destination, frozen while
    // stalled so the load's rd survives until the consumer resumes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_rd <= '0;
            hold_we <= 1'b0;
        end else if (flush_mw_o) begin
            hold_rd <= '0;
            hold_we <= 1'b0;
        end else if (state != LD_STALL) begin
            hold_rd <= rd_mw;
            hold_we <= mw_wr;
        end
    end

    assign hz.fwd_a     = fwd_a_o;
    assign hz.fwd_b     = fwd_b_o;
    assign hz.stall_if  = stall_o;
    assign hz.stall_de  = stall_o;
    assign hz.bubble_mw = stall_o;
    assign hz.flush_de  = flush_de_o;
    assign hz.flush_mw  = flush_mw_o;
    assign hz.busy      = !rst && (state != RUN);

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (LOAD_STALL=2, FLUSH_CYCLES=3).
// Each step drives the stage contents, queues the expected output vector
// {fwd_a, fwd_b, stall_if, stall_de, bubble_mw, flush_de, flush_mw, busy},
// and compares it on the following falling edge.
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.XLEN(32)) hz ();

    hazard_ctrl_unit #(
        .XLEN         (32),
        .REG_AW       (5),
        .LOAD_STALL   (2),
        .FLUSH_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_t;

    sb_t sbq[$];

    function automatic logic [31:0] rtype(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [9:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic s, input logic fde, input logic fmw,
                                      input logic bsy);
        return {fa, fb, s, s, s, fde, fmw, bsy};
    endfunction

    task automatic drv(input logic [31:0] de, input logic [31:0] mw, input logic rw,
                       input logic br, input logic mret, input logic [1:0] irq);
        hz.instr_de     = de;
        hz.instr_mw     = mw;
        hz.reg_write_mw = rw;
        hz.br_taken     = br;
        hz.is_mret_mw   = mret;
        hz.interrupt    = irq;
    endtask

    task automatic step(input string tag, input logic [9:0] e);
        sb_t        it;
        logic [9:0] obs;
        sbq.push_back('{tag, e});
        @(negedge clk);
        it  = sbq.pop_front();
        obs = {hz.fwd_a, hz.fwd_b, hz.stall_if, hz.stall_de, hz.bubble_mw,
               hz.flush_de, hz.flush_mw, hz.busy};
        checks++;
        assert (obs === it.exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] nop, add5, add7, add0, lw7, sw9;
        logic [31:0] a6_55, a6_51, a6_15, lui65, addi_rs2, sub817, a8_71, a10_99, a10_00;
        logic [9:0]  z, stl, stl_b, fl0, fl_b;

        nop      = 32'h0000_0013;
        add5     = rtype(7'b0110011, 5'd5, 5'd1, 5'd2);
        add7     = rtype(7'b0110011, 5'd7, 5'd1, 5'd2);
        add0     = rtype(7'b0110011, 5'd0, 5'd1, 5'd2);
        lw7      = {12'd0, 5'd2, 3'b010, 5'd7, 7'b0000011};
        sw9      = {7'd0, 5'd9, 5'd2, 3'b010, 5'd9, 7'b0100011};
        a6_55    = rtype(7'b0110011, 5'd6, 5'd5, 5'd5);
        a6_51    = rtype(7'b0110011, 5'd6, 5'd5, 5'd1);
        a6_15    = rtype(7'b0110011, 5'd6, 5'd1, 5'd5);
        lui65    = rtype(7'b0110111, 5'd6, 5'd5, 5'd5);
        addi_rs2 = rtype(7'b0010011, 5'd6, 5'd1, 5'd5);
        sub817   = {7'b0100000, 5'd7, 5'd1, 3'b000, 5'd8, 7'b0110011};
        a8_71    = rtype(7'b0110011, 5'd8, 5'd7, 5'd1);
        a10_99   = rtype(7'b0110011, 5'd10, 5'd9, 5'd9);
        a10_00   = rtype(7'b0110011, 5'd10, 5'd0, 5'd0);

        z     = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        stl   = ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        stl_b = ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        fl0   = ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        fl_b  = ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reset gating: interrupt pending while rst is high.
        rst = 1'b1;
        drv(nop, nop, 1'b0, 1'b0, 1'b0, 2'b01);
        @(posedge clk);
        #1;
        step("rst_gate", z);
        rst = 1'b0;
        drv(nop, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("idle", z);

        // Forwarding from MW and from the hold register.
        drv(a6_55, add5, 1'b1, 1'b0, 1'b0, 2'b00);
        step("fwd_mw_both", ex(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
        drv(a6_51, add5, 1'b1, 1'b0, 1'b0, 2'b00);
        step("fwd_mw_prio", ex(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        drv(a6_15, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("fwd_hold_b", ex(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
        drv(a6_55, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("hold_cleared", z);
        drv(lui65, add5, 1'b1, 1'b0, 1'b0, 2'b00);
        step("lui_no_rs", z);
        drv(addi_rs2, add5, 1'b1, 1'b0, 1'b0, 2'b00);
        step("rs2_unused", z);

        // Load-use on rs2, two stall cycles, then hold forwarding.
        drv(sub817, lw7, 1'b1, 1'b0, 1'b0, 2'b00);
        step("lu_stall0", stl);
        drv(sub817, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("lu_stall1", stl_b);
        step("lu_post_fwd", ex(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));

        // Branch during LD_STALL is ignored.
        drv(sub817, lw7, 1'b1, 1'b0, 1'b0, 2'b00);
        step("lu2_stall0", stl);
        drv(sub817, nop, 1'b0, 1'b1, 1'b0, 2'b00);
        step("lu2_br_ignored", stl_b);
        drv(sub817, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("lu2_post_fwd", ex(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));

        // Load-use on rs1, pre-empted by an interrupt while stalled.
        drv(a8_71, lw7, 1'b1, 1'b0, 1'b0, 2'b00);
        step("lu3_stall0", stl);
        drv(a8_71, nop, 1'b0, 1'b0, 1'b0, 2'b01);
        step("lu3_irq", fl_b);
        drv(a8_71, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("lu3_flush1", fl_b);
        step("lu3_flush2", fl_b);
        step("lu3_post", z);

        // Lone branch: one-cycle DE flush.
        drv(nop, nop, 1'b0, 1'b1, 1'b0, 2'b00);
        step("br_flush", ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
        drv(nop, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("br_one_cycle", z);

        // Interrupt beats branch and load-use; MW keeps writing x7 during the flush.
        drv(sub817, lw7, 1'b1, 1'b1, 1'b0, 2'b01);
        step("irq_flush0", fl0);
        drv(sub817, add7, 1'b1, 1'b0, 1'b0, 2'b00);
        step("irq_flush1", fl_b);
        step("irq_flush2", fl_b);
        chk1("irq_hold_we", dut.hold_we, 1'b0);
        drv(sub817, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("irq_run", z);
        drv(nop, nop, 1'b0, 1'b0, 1'b0, 2'b11);
        step("irq11_ignored", z);
        drv(nop, nop, 1'b0, 1'b0, 1'b0, 2'b10);
        step("irq10_ignored", z);

        // mret during FLUSH reloads the counter.
        drv(nop, nop, 1'b0, 1'b0, 1'b0, 2'b01);
        step("re_f0", fl0);
        drv(nop, nop, 1'b0, 1'b0, 1'b1, 2'b00);
        step("re_mret", fl_b);
        drv(nop, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("re_f2", fl_b);
        step("re_f3", fl_b);
        step("re_run", z);

        // Stores and x0 never forward.
        drv(a10_99, sw9, 1'b1, 1'b0, 1'b0, 2'b00);
        step("st_no_fwd", z);
        drv(a10_99, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("st_no_hold", z);
        drv(a10_00, add0, 1'b1, 1'b0, 1'b0, 2'b00);
        step("x0_no_fwd", z);
        drv(a10_00, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        step("x0_no_hold", z);

        // Reset asserted mid-FLUSH.
        drv(nop, nop, 1'b0, 1'b0, 1'b0, 2'b01);
        step("rm_f0", fl0);
        drv(nop, nop, 1'b0, 1'b0, 1'b0, 2'b00);
        rst = 1'b1;
        #1;
        chk1("rm_state_run", dut.state === 2'd0, 1'b1);
        step("rm_rst", z);
        rst = 1'b0;
        step("rm_after", z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the pipeline forwarding/flush logic.
- Sits between the decode/execute (DE) and memory/writeback (MW) stages. Produces operand-forward selects, pipeline stalls and stage flushes.
- New capabilities:
  - independent rs1/rs2 forwarding;
  - a second forwarding source from an internal writeback-hold register;
  - multi-cycle load-use stalling;
  - multi-cycle interrupt/mret flush sequencing via a small FSM.

Parameters:
- XLEN, 32, instruction/data width.
- REG_AW, 5, register address width.
- LOAD_STALL, 1, stall cycles inserted for a load-use hazard (1..7).
- FLUSH_CYCLES, 2, cycles flush is held after an interrupt or mret (1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- instr_de  in  XLEN  instruction in DE stage
- instr_mw  in  XLEN  instruction in MW stage
- reg_write_mw  in  1  MW instruction writes register file
- br_taken  in  1  branch/jump resolved taken in DE
- is_mret_mw  in  1  mret in MW
- interrupt  in  2  interrupt status; 2'b01 = interrupt taken
- fwd_a  out  2  rs1 select: 00 regfile, 01 MW result, 10 hold register
- fwd_b  out  2  rs2 select, same encoding
- stall_if  out  1  hold PC/fetch register
- stall_de  out  1  hold DE register
- bubble_mw  out  1  inject NOP into MW on next edge
- flush_de  out  1  clear DE register
- flush_mw  out  1  clear MW register
- busy  out  1  FSM not in RUN

Behaviour:
Reset:
- Async; state=RUN, cnt=0, hold_rd=0, hold_we=0.
- Combinational outputs all 0 while rst=1.

Decode (combinational):
- rs1 used unless DE opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
- rs2 used only for opcodes 0110011, 0100011, 1100011.
- MW writes rd iff reg_write_mw=1, rd!=0, and opcode is not store 0100011 or branch 1100011.
- MW is a load iff opcode 0000011.
- JAL/JALR results are forwardable.

Forwarding, per operand independently:
- 01 if MW writes rd and rd == rsX, MW is not a load, and rsX is used.
- Else 10 if hold_we=1 and hold_rd == rsX, rsX used, rsX!=0.
- Else 00.
- MW match has priority over hold.
- Both fwd_a and fwd_b may be non-zero in the same cycle.

Hold register:
- On each clk edge: hold_rd <= instr_mw[11:7], hold_we <= (MW writes rd).
- Not updated while state=LD_STALL.
- Cleared to 0 on any edge where flush_mw=1.

Priority (highest first): rst > interrupt==01 | is_mret_mw > br_taken > load-use > forwarding.

FSM:
- RUN:
  - Interrupt/mret: flush_de=flush_mw=1, fwd=00 this cycle. Next state FLUSH with cnt=FLUSH_CYCLES-1, or stay RUN if FLUSH_CYCLES==1.
  - Else br_taken: flush_de=1 for this cycle only; stay RUN.
  - Else load-use (MW load writing rd, rd matching a used rs1/rs2 of DE): stall_if=stall_de=bubble_mw=1, fwd=00. Next state LD_STALL with cnt=LOAD_STALL-1, or stay RUN if LOAD_STALL==1.
- LD_STALL:
  - stall_if=stall_de=bubble_mw=1; decrement cnt; RUN when cnt==0 at the edge.
  - Interrupt/mret here pre-empts: go to FLUSH per the RUN rule.
  - br_taken is ignored while stalled.
- FLUSH:
  - flush_de=flush_mw=1; all other outputs 0; decrement cnt; RUN when cnt==0.
  - A new interrupt/mret reloads cnt=FLUSH_CYCLES-1.
- busy=1 in LD_STALL and FLUSH.

Post-stall:
- After the stall, the load rd lives in hold and is forwarded with select 10.
- A DE instruction resumed after LD_STALL must see fwd=10 for the load rd.

Test Plan:
- Reset mid-FLUSH (FLUSH_CYCLES=2) -> all outputs 0 immediately; state RUN after release.
- MW `add x5`, DE `add x6,x5,x5`, reg_write_mw=1 -> fwd_a=01, fwd_b=01, no stall/flush.
- MW `lw x7`, DE `sub x8,x1,x7`, LOAD_STALL=2 -> stall_if/stall_de/bubble_mw=1 for 2 cycles. Next cycle fwd_b=10, fwd_a=00.
- interrupt=01 with br_taken=1 and a pending load-use, FLUSH_CYCLES=3 -> flush_de=flush_mw=1 for 3 consecutive cycles, stall=0, then RUN; hold_we=0.
- br_taken=1 alone -> flush_de=1 for exactly 1 cycle, flush_mw=0.
- MW `sw x9`, DE uses x9; then MW writes x0 -> fwd stays 00 in both cases.
